// File: rtl/msg_buf_tx_if.sv
// Byte-write strobe and UART/status signals between a message source and msg_buf_tx.
interface msg_buf_tx_if;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_data_en;
  logic       txd;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;
  logic       busy;

  modport master (
    output tx_fifo_data, tx_fifo_data_en,
    input  txd, fifo_empty, fifo_full, overflow, busy
  );

  modport slave (
    input  tx_fifo_data, tx_fifo_data_en,
    output txd, fifo_empty, fifo_full, overflow, busy
  );
endinterface

// File: rtl/msg_buf_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter; a write into an idle, empty block starts the start bit two edges later.
// No backpressure: a strobe while full is dropped and reported by a one-cycle overflow pulse.
module msg_buf_tx #(
  parameter int BAUD_DIV   = 347,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstb,
  msg_buf_tx_if.slave bus
);
  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);
  localparam logic [11:0]           BAUD_LAST = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [11:0]           baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_en, pop, baud_done;
  logic [7:0]            mem_q [DEPTH];

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.tx_fifo_data;
  end

  always_comb begin
    wr_en      = bus.tx_fifo_data_en && !full_q;
    pop        = (state_q == S_IDLE) && !empty_q;
    overflow_d = bus.tx_fifo_data_en && full_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    baud_done = (baud_q == BAUD_LAST);
    unique case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          state_d = S_START;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // txd is registered, so it is computed from where the FSM is going.
    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.txd        = txd_q;
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_full  = full_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: doc/msg_buf_tx.md
MSG_BUF_TX -- requirements
Module: msg_buf_tx

Interface
REQ-001 The parameter BAUD_DIV SHALL default to 347 and SHALL set the clk cycles per UART bit (40 MHz / 115200); legal range is 2..4095.
REQ-002 The parameter DEPTH_LOG2 SHALL default to 4 and SHALL give a FIFO depth of 2**DEPTH_LOG2 bytes (16).
REQ-003 clk  input  1  system clock, 40 MHz; the block has one clock, and every register is clocked on the rising edge of clk.
REQ-004 rstb  input  1  reset, asynchronous and active-low.
REQ-005 tx_fifo_data  input  8  message byte to transmit.
REQ-006 tx_fifo_data_en  input  1  single-cycle write strobe for tx_fifo_data.
REQ-007 txd  output  1  UART serial output, 8N1, LSB first, idle high.
REQ-008 fifo_empty  output  1  FIFO holds 0 bytes.
REQ-009 fifo_full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-010 overflow  output  1  one-cycle pulse: a write strobe was dropped.
REQ-011 busy  output  1  high while the transmit FSM is not in IDLE.

Function
REQ-012 The FIFO SHALL use a (DEPTH_LOG2+1)-bit occupancy count and DEPTH_LOG2-bit read/write pointers; pointers SHALL wrap from 2**DEPTH_LOG2-1 to 0.
REQ-013 A write SHALL occur on a clk edge with tx_fifo_data_en=1 and fifo_full=0 as sampled on that edge, storing tx_fifo_data at the write pointer.
REQ-014 A strobe with fifo_full=1 SHALL be dropped and SHALL assert overflow for exactly the next cycle, even when a pop occurs on the same edge; FIFO contents and pointers SHALL be unchanged by the dropped write.
REQ-015 Write and pop on the same edge (FIFO non-empty, not full) SHALL leave the count unchanged and advance both pointers.
REQ-016 fifo_empty and fifo_full SHALL be registered, and SHALL reflect the count after each edge.
REQ-017 The transmit FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-018 IDLE: txd=1; when fifo_empty=0, the FSM SHALL pop one byte into the shift register, clear the baud counter and the bit counter, and go to START on the same edge.
REQ-019 START: txd=0 for BAUD_DIV cycles, then DATA.
REQ-020 DATA: txd=shift[0] for BAUD_DIV cycles per bit, shifting right after each bit; after 8 bits, go to STOP.
REQ-021 STOP: txd=1 for BAUD_DIV cycles, then IDLE.
REQ-022 txd SHALL be driven from a register, with no combinational path from any input.
REQ-023 Latency: a write into an empty FIFO with the FSM in IDLE at edge N SHALL make fifo_empty=0 after edge N; the pop SHALL occur at edge N+1, and txd SHALL fall after edge N+1.
REQ-024 Back-to-back bytes SHALL have exactly one IDLE cycle between the end of STOP and the next start bit, so each frame takes 10*BAUD_DIV+1 cycles.
REQ-025 The baud counter SHALL count 0..BAUD_DIV-1 and SHALL reset to 0 at each bit boundary; it SHALL NOT be free-running.
REQ-026 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-027 While rstb=0: txd=1, fifo_empty=1, fifo_full=0, overflow=0, busy=0, state=IDLE, and all pointers and counters are 0; FIFO RAM contents need not be reset.
REQ-028 Assertion of rstb mid-frame SHALL abort the frame immediately, with txd=1, and SHALL discard all queued bytes.
REQ-029 After rstb deasserts, no write SHALL be lost: the first edge with tx_fifo_data_en=1 SHALL be accepted.

Verification (BAUD_DIV=4, DEPTH_LOG2=4)
REQ-030 Single byte: write 0x55 into an empty FIFO -> txd after the pop edge: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles, fifo_empty=1 after the pop.
REQ-031 Burst: write 0x41,0x42,0x43 on consecutive cycles -> three frames are decoded in order, each 41 cycles start-to-start, with no overflow.
REQ-032 Full/overflow: write 18 bytes 0x00..0x11 on consecutive cycles while the first frame is in progress -> the first byte is popped, so the FIFO holds 0x01..0x10 and fifo_full=1; 0x11 is dropped with a single overflow pulse; output order is 0x00..0x10.
REQ-033 Simultaneous write and pop: the FIFO holds 1 byte, the FSM reaches IDLE and a write arrives on the pop edge -> the count stays 1 and the byte order is preserved.
REQ-034 Wrap-around: stream 40 bytes with a 50-cycle gap between writes -> pointers wrap twice and all 40 bytes are received intact.
REQ-035 Reset mid-frame: drop rstb during bit 3 of 0xA5 with 4 bytes queued -> txd=1, fifo_empty=1 and busy=0 immediately; after release, a new write of 0x3C is transmitted correctly.
